// File: rtl/freq_uart_query.sv
// Host-side UART query initiator: sends a 32-bit trigger word, then collects the
// 4-byte {high_cnt, low_cnt} reply with timeout and framing checks.
module freq_uart_query #(
  parameter int          CLK_FREQ       = 50_000_000,
  parameter int          BAUD           = 115200,
  parameter logic [31:0] TRIGGER_VALUE  = 32'hFFFFA5A5,
  parameter int          MSB_FIRST      = 1,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        query_req,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        busy,
  output logic [15:0] high_cnt,
  output logic [15:0] low_cnt,
  output logic        resp_valid,
  output logic        timeout,
  output logic        frame_err
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [31:0] BIT_LAST     = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HALF_LAST    = 32'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] TMO_LAST     = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          MSBF         = (MSB_FIRST != 0);

  typedef enum logic [1:0] {IDLE, TX, RX} state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_sync;
  logic [9:0]  tx_shift;
  logic [31:0] bit_cnt;
  logic [3:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic        rx_active;
  logic [7:0]  rx_shift;
  logic [31:0] reply_shadow;
  logic [31:0] reply_next;
  logic [31:0] tmo_cnt;

  // Wire position k maps to byte slot (3-k) of a 32-bit word when MSB goes first.
  function automatic logic [1:0] wire_slot(input logic [1:0] idx);
    return MSBF ? ~idx : idx;
  endfunction

  function automatic logic [9:0] tx_frame(input logic [1:0] idx);
    logic [1:0] s;
    s = wire_slot(idx);
    return {1'b1, TRIGGER_VALUE[{s, 3'b000} +: 8], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    reply_next = reply_shadow;
    reply_next[{wire_slot(byte_idx), 3'b000} +: 8] = rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      uart_tx      <= 1'b1;
      busy         <= 1'b0;
      high_cnt     <= '0;
      low_cnt      <= '0;
      resp_valid   <= 1'b0;
      timeout      <= 1'b0;
      frame_err    <= 1'b0;
      tx_shift     <= '1;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      rx_active    <= 1'b0;
      rx_shift     <= '0;
      reply_shadow <= '0;
      tmo_cnt      <= '0;
    end else begin
      resp_valid <= 1'b0;
      timeout    <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (query_req) begin
            state    <= TX;
            busy     <= 1'b1;
            tx_shift <= tx_frame(2'd0);
            uart_tx  <= 1'b0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end

        // tx_shift[0] is the bit currently on the line; stop bits refill with 1s.
        TX: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == 4'd9) begin
              if (byte_idx == 2'd3) begin
                state     <= RX;
                byte_idx  <= '0;
                rx_active <= 1'b0;
                tmo_cnt   <= '0;
                uart_tx   <= 1'b1;
              end else begin
                byte_idx <= byte_idx + 2'd1;
                tx_shift <= tx_frame(byte_idx + 2'd1);
                uart_tx  <= 1'b0;
                bit_idx  <= '0;
              end
            end else begin
              bit_idx  <= bit_idx + 4'd1;
              tx_shift <= {1'b1, tx_shift[9:1]};
              uart_tx  <= tx_shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 32'd1;
          end
        end

        RX: begin
          if (!rx_active) begin
            if (!rx_sync) begin
              rx_active <= 1'b1;
              bit_cnt   <= '0;
              bit_idx   <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
              timeout <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 32'd1;
            end
          end else if (bit_idx == 4'd0) begin
            // Half-bit recheck rejects short low glitches as false starts.
            if (bit_cnt == HALF_LAST) begin
              bit_cnt <= '0;
              if (rx_sync) rx_active <= 1'b0;
              else         bit_idx   <= 4'd1;
            end else begin
              bit_cnt <= bit_cnt + 32'd1;
            end
          end else if (bit_cnt != BIT_LAST) begin
            bit_cnt <= bit_cnt + 32'd1;
          end else begin
            bit_cnt <= '0;
            if (bit_idx != 4'd9) begin
              rx_shift <= {rx_sync, rx_shift[7:1]};
              bit_idx  <= bit_idx + 4'd1;
            end else if (!rx_sync) begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              rx_active <= 1'b0;
              state     <= IDLE;
            end else begin
              rx_active    <= 1'b0;
              tmo_cnt      <= '0;
              reply_shadow <= reply_next;
              byte_idx     <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                {high_cnt, low_cnt} <= reply_next;
                resp_valid          <= 1'b1;
                busy                <= 1'b0;
                state               <= IDLE;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_uart_query.sv
// Randomized self-checking bench for freq_uart_query: decodes the trigger word off
// uart_tx and answers with modelled replies, including short, corrupt and glitchy ones.
module tb_freq_uart_query;

  localparam int          CPB  = 10;
  localparam int          TMO  = 200;
  localparam logic [31:0] TRIG = 32'hFFFFA5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        query_req;
  logic        uart_rx;
  logic        uart_tx;
  logic        busy;
  logic [15:0] high_cnt;
  logic [15:0] low_cnt;
  logic        resp_valid;
  logic        timeout;
  logic        frame_err;

  freq_uart_query #(
    .CLK_FREQ(1000), .BAUD(100), .TRIGGER_VALUE(TRIG),
    .MSB_FIRST(1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .query_req(query_req), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .busy(busy), .high_cnt(high_cnt), .low_cnt(low_cnt),
    .resp_valid(resp_valid), .timeout(timeout), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int   checkCount = 0;
  int   passCount  = 0;
  int   cycle      = 0;
  int   respCount  = 0;
  int   tmoCount   = 0;
  int   ferrCount  = 0;
  int   pulseCycle = 0;
  int   stopEndCycle = 0;
  logic busyAtPulse = 1'b1;
  bit   trackBusy = 0;
  bit   busyOk    = 1;
  logic [15:0] modelHigh = '0;
  logic [15:0] modelLow  = '0;

  // Pulse monitor samples just after each active edge.
  always @(posedge clk) begin
    #1;
    cycle++;
    if (resp_valid === 1'b1) respCount++;
    if (timeout === 1'b1)    tmoCount++;
    if (frame_err === 1'b1)  ferrCount++;
    if (resp_valid === 1'b1 || timeout === 1'b1 || frame_err === 1'b1) begin
      pulseCycle  = cycle;
      busyAtPulse = busy;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (trackBusy && busy !== 1'b1) busyOk = 0;
    end
  endtask

  task automatic sendByte(input logic [7:0] d, input logic stopVal);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(CPB);
    end
    uart_rx = stopVal;
    tick(CPB);
    stopEndCycle = cycle;
    uart_rx = 1'b1;
  endtask

  // Samples every uart_tx bit at mid-bit and rebuilds the word in wire order.
  task automatic decodeTx(input bit pokeReq);
    logic [31:0] txWord;
    logic [7:0]  b;
    bit          found;
    bit          framingOk;
    found = 0;
    framingOk = 1;
    txWord = '0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (uart_tx === 1'b0) found = 1;
      else tick(1);
    end
    checkOutput("tx_start_seen", 32'(found), 32'd1);
    busyOk = 1;
    trackBusy = 1;
    tick(CPB / 2);
    for (int k = 0; k < 4; k++) begin
      if (uart_tx !== 1'b0) framingOk = 0;
      if (pokeReq && k == 2) begin
        query_req = 1'b1;
        tick(1);
        query_req = 1'b0;
        tick(CPB - 1);
      end else begin
        tick(CPB);
      end
      for (int i = 0; i < 8; i++) begin
        b[i] = uart_tx;
        if (i < 7) tick(CPB);
      end
      tick(CPB);
      if (uart_tx !== 1'b1) framingOk = 0;
      txWord = {txWord[23:0], b};
      tick(CPB);
    end
    trackBusy = 0;
    checkOutput("tx_word", txWord, TRIG);
    checkOutput("tx_framing", 32'(framingOk), 32'd1);
    checkOutput("busy_during_tx", 32'(busyOk), 32'd1);
  endtask

  // One full query: trigger, then a reply of nBytes with an optional bad stop bit.
  task automatic applyStimulus(input logic [31:0] reply, input int nBytes,
                               input int badIdx, input bit glitch, input bit pokeReq);
    int r0, t0, f0, expResp, expTmo, expFerr, delta;
    logic [7:0] b;
    r0 = respCount; t0 = tmoCount; f0 = ferrCount;
    query_req = 1'b1;
    tick(1);
    query_req = 1'b0;
    decodeTx(pokeReq);
    tick($urandom_range(0, 20));
    if (glitch) begin
      uart_rx = 1'b0;
      tick(3);
      uart_rx = 1'b1;
      tick(20);
    end
    for (int k = 0; k < nBytes; k++) begin
      b = 8'((reply >> (24 - 8 * k)) & 32'hFF);
      sendByte(b, (k == badIdx) ? 1'b0 : 1'b1);
      if (k == badIdx) break;
      if (k < nBytes - 1) tick($urandom_range(0, 40));
    end
    expFerr = (badIdx >= 0 && badIdx < nBytes) ? 1 : 0;
    expTmo  = (!expFerr && nBytes < 4) ? 1 : 0;
    expResp = (!expFerr && !expTmo) ? 1 : 0;
    for (int i = 0; i < 400; i++) begin
      if ((respCount - r0) + (tmoCount - t0) + (ferrCount - f0) != 0) break;
      tick(1);
    end
    tick(3);
    if (expResp != 0) begin
      modelHigh = reply[31:16];
      modelLow  = reply[15:0];
    end
    checkOutput("resp_valid_pulses", 32'(respCount - r0), 32'(expResp));
    checkOutput("timeout_pulses", 32'(tmoCount - t0), 32'(expTmo));
    checkOutput("frame_err_pulses", 32'(ferrCount - f0), 32'(expFerr));
    checkOutput("high_cnt", {16'h0, high_cnt}, {16'h0, modelHigh});
    checkOutput("low_cnt", {16'h0, low_cnt}, {16'h0, modelLow});
    checkOutput("busy_at_pulse", {31'h0, busyAtPulse}, 32'd0);
    checkOutput("busy_after", {31'h0, busy}, 32'd0);
    if (expTmo != 0 && nBytes > 0) begin
      delta = pulseCycle - stopEndCycle;
      checkOutput("timeout_delay", 32'(delta >= TMO - 10 && delta <= TMO + 10), 32'd1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mode, n, bad, r0;
    rst = 1'b1;
    query_req = 1'b0;
    uart_rx = 1'b1;
    tick(3);
    checkOutput("reset_uart_tx", {31'h0, uart_tx}, 32'd1);
    checkOutput("reset_busy", {31'h0, busy}, 32'd0);
    checkOutput("reset_high", {16'h0, high_cnt}, 32'd0);
    checkOutput("reset_low", {16'h0, low_cnt}, 32'd0);
    checkOutput("reset_pulses", {29'h0, resp_valid, timeout, frame_err}, 32'd0);
    rst = 1'b0;
    tick(2);

    r0 = respCount + tmoCount + ferrCount;
    sendByte(8'h3C, 1'b1);
    tick(5);
    checkOutput("idle_rx_ignored", 32'(respCount + tmoCount + ferrCount - r0), 32'd0);
    checkOutput("idle_busy", {31'h0, busy}, 32'd0);

    applyStimulus(32'h12345678, 4, -1, 0, 1);
    applyStimulus($urandom, 2, -1, 0, 0);
    applyStimulus($urandom, 4, 2, 0, 0);
    applyStimulus($urandom, 4, -1, 1, 0);

    query_req = 1'b1;
    tick(1);
    query_req = 1'b0;
    for (int i = 0; i < 10 && uart_tx !== 1'b0; i++) tick(1);
    tick(302);
    checkOutput("mid_tx_start_bit", {31'h0, uart_tx}, 32'd0);
    rst = 1'b1;
    tick(1);
    checkOutput("rst_mid_tx_uart_tx", {31'h0, uart_tx}, 32'd1);
    checkOutput("rst_mid_tx_busy", {31'h0, busy}, 32'd0);
    checkOutput("rst_mid_tx_high", {16'h0, high_cnt}, 32'd0);
    rst = 1'b0;
    modelHigh = '0;
    modelLow  = '0;
    tick(3);
    applyStimulus($urandom, 4, -1, 0, 0);

    for (int q = 0; q < 6; q++) begin
      mode = $urandom_range(0, 3);
      n    = 4;
      bad  = -1;
      if (mode == 2) n = $urandom_range(0, 3);
      if (mode == 3) bad = $urandom_range(0, 3);
      applyStimulus($urandom, n, bad, 1'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
